// File: rtl/dc_filter_job_arbiter.sv
// Round-robin arbiter that shares one DC filter between N_SRC pixel sources.
// One job (IN_PER_OUT beats in, one result out) is in flight at a time; the held grant routes the result.
module dc_filter_job_arbiter #(
    parameter int N_SRC      = 4,
    parameter int IN_PER_OUT = 9,
    parameter int DW         = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_SRC-1:0]      i_src_vld,
    input  logic [N_SRC*DW-1:0]   i_src_data,
    output logic [N_SRC-1:0]      o_src_busy,
    output logic [N_SRC-1:0]      o_rsp_vld,
    output logic [DW-1:0]         o_rsp_data,
    input  logic [N_SRC-1:0]      i_rsp_busy,
    output logic                  o_flt_vld,
    output logic [DW-1:0]         o_flt_data,
    input  logic                  i_flt_busy,
    input  logic                  i_flt_res_vld,
    input  logic [DW-1:0]         i_flt_res_data,
    output logic                  o_flt_res_busy,
    output logic [N_SRC-1:0]      o_grant,
    output logic [15:0]           o_job_cnt
);

    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  g_q, g_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [15:0]    job_cnt_q, job_cnt_d;

    logic [GW-1:0]  pick;
    logic [GW-1:0]  idx;
    logic           feed_xfer;
    logic           rsp_xfer;
    logic           last_beat;
    logic [DW-1:0]  src_word [N_SRC];

    genvar k;
    generate
        for (k = 0; k < N_SRC; k++) begin : g_src_word
            assign src_word[k] = i_src_data[k*DW +: DW];
        end
    endgenerate

    // Scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = rr_ptr_q;
        idx  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_ptr_q) + i) % N_SRC);
            if (i_src_vld[idx]) begin
                pick = idx;
            end
        end
    end

    assign feed_xfer = (state_q == ST_FEED) && i_src_vld[g_q] && !i_flt_busy;
    assign rsp_xfer  = (state_q == ST_WAIT) && i_flt_res_vld && !i_rsp_busy[g_q];
    assign last_beat = (bcnt_q == 8'(IN_PER_OUT - 1));

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_ptr_d  = rr_ptr_q;
        bcnt_d    = bcnt_q;
        job_cnt_d = job_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_src_vld) begin
                    g_d     = pick;
                    bcnt_d  = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (feed_xfer) begin
                    bcnt_d = bcnt_q + 8'd1;
                    if (last_beat) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rsp_xfer) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = (g_q == GW'(N_SRC - 1)) ? '0 : g_q + 1'b1;
                    job_cnt_d = job_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            rr_ptr_q  <= '0;
            bcnt_q    <= '0;
            job_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_ptr_q  <= rr_ptr_d;
            bcnt_q    <= bcnt_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    // Datapath steering is combinational off the registered state and grant.
    always_comb begin
        o_src_busy     = '1;
        o_rsp_vld      = '0;
        o_grant        = '0;
        o_flt_vld      = 1'b0;
        o_flt_res_busy = 1'b1;
        o_flt_data     = src_word[g_q];
        o_rsp_data     = i_flt_res_data;
        case (state_q)
            ST_FEED: begin
                o_flt_vld       = i_src_vld[g_q];
                o_src_busy[g_q] = i_flt_busy;
                o_grant[g_q]    = 1'b1;
            end
            ST_WAIT: begin
                o_rsp_vld[g_q] = i_flt_res_vld;
                o_flt_res_busy = i_rsp_busy[g_q];
                o_grant[g_q]   = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_job_cnt = job_cnt_q;

endmodule

// File: tb/tb_dc_filter_job_arbiter.sv
// Directed bench for dc_filter_job_arbiter: the bench plays the sources, the filter and the result sinks.
module tb_dc_filter_job_arbiter;

    localparam int N_SRC      = 4;
    localparam int IN_PER_OUT = 9;
    localparam int DW         = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_SRC-1:0]    src_vld;
    logic [N_SRC*DW-1:0] src_data;
    logic [N_SRC-1:0]    src_busy;
    logic [N_SRC-1:0]    rsp_vld;
    logic [DW-1:0]       rsp_data;
    logic [N_SRC-1:0]    rsp_busy;
    logic                flt_vld;
    logic [DW-1:0]       flt_data;
    logic                flt_busy;
    logic                flt_res_vld;
    logic [DW-1:0]       flt_res_data;
    logic                flt_res_busy;
    logic [N_SRC-1:0]    grant;
    logic [15:0]         job_cnt;

    int total = 0;
    int bad   = 0;

    int               next_beat [N_SRC];
    int               beat_limit [N_SRC];
    logic [N_SRC-1:0] src_enable;
    bit               auto_filter;
    bit               toggle_busy;
    int               flt_feed_cnt;
    int               results_given;
    int               bad_src_cnt;
    logic [N_SRC-1:0] prev_grant;
    logic [DW-1:0]    flt_log [$];
    int               grant_log [$];
    int               rsp_src_log [$];
    logic [DW-1:0]    rsp_data_log [$];

    logic [N_SRC-1:0] obs_grant, obs_src_busy, obs_rsp_vld;
    logic             obs_flt_vld, obs_flt_res_busy;
    logic [DW-1:0]    obs_rsp_data;
    logic [15:0]      obs_job_cnt;
    bit               obs_res_taken;

    always #5 clk = ~clk;

    dc_filter_job_arbiter #(
        .N_SRC(N_SRC), .IN_PER_OUT(IN_PER_OUT), .DW(DW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_src_vld(src_vld),
        .i_src_data(src_data),
        .o_src_busy(src_busy),
        .o_rsp_vld(rsp_vld),
        .o_rsp_data(rsp_data),
        .i_rsp_busy(rsp_busy),
        .o_flt_vld(flt_vld),
        .o_flt_data(flt_data),
        .i_flt_busy(flt_busy),
        .i_flt_res_vld(flt_res_vld),
        .i_flt_res_data(flt_res_data),
        .o_flt_res_busy(flt_res_busy),
        .o_grant(grant),
        .o_job_cnt(job_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Beat n (counting from 1) of source s carries its source id in the top nibble.
    function automatic logic [DW-1:0] beatData(input int s, input int n);
        return {4'(s), 4'h0, 16'(n)};
    endfunction

    function automatic int oneHotIdx(input logic [N_SRC-1:0] v);
        int r = -1;
        for (int i = 0; i < N_SRC; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic driveSources();
        for (int s = 0; s < N_SRC; s++) begin
            src_vld[s]              = src_enable[s] && (next_beat[s] < beat_limit[s]);
            src_data[s*DW +: DW]    = beatData(s, next_beat[s] + 1);
        end
    endtask

    task automatic applyStimulus(input int src, input int limit);
        src_enable[src] = 1'b1;
        beat_limit[src] = limit;
        driveSources();
    endtask

    // Observe at the falling edge, then advance past the rising edge and update the bench-side agents.
    task automatic stepCycle();
        logic [N_SRC-1:0] acc;
        bit               flt_x;
        @(negedge clk);
        obs_grant        = grant;
        obs_src_busy     = src_busy;
        obs_rsp_vld      = rsp_vld;
        obs_flt_vld      = flt_vld;
        obs_flt_res_busy = flt_res_busy;
        obs_rsp_data     = rsp_data;
        obs_job_cnt      = job_cnt;
        acc = src_vld & ~src_busy;
        for (int s = 0; s < N_SRC; s++) if (acc[s] && !grant[s]) bad_src_cnt++;
        flt_x = flt_vld && !flt_busy;
        if (flt_x) flt_log.push_back(flt_data);
        for (int s = 0; s < N_SRC; s++) begin
            if (rsp_vld[s] && !rsp_busy[s]) begin
                rsp_src_log.push_back(s);
                rsp_data_log.push_back(rsp_data);
            end
        end
        obs_res_taken = flt_res_vld && !flt_res_busy;
        if (grant != '0 && prev_grant == '0) grant_log.push_back(oneHotIdx(grant));
        prev_grant = grant;
        @(posedge clk);
        #1;
        for (int s = 0; s < N_SRC; s++) if (acc[s]) next_beat[s]++;
        if (auto_filter) begin
            if (obs_res_taken) begin
                flt_res_vld = 1'b0;
                results_given++;
            end
            if (flt_x) begin
                flt_feed_cnt++;
                if (flt_feed_cnt == IN_PER_OUT) begin
                    flt_feed_cnt = 0;
                    flt_res_vld  = 1'b1;
                    flt_res_data = 24'h050505 + 24'(results_given);
                end
            end
        end
        if (toggle_busy) flt_busy = ~flt_busy;
        driveSources();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
            next_beat[s]  = 0;
            beat_limit[s] = 0;
        end
        src_enable    = '0;
        auto_filter   = 1'b1;
        toggle_busy   = 1'b0;
        flt_feed_cnt  = 0;
        results_given = 0;
        bad_src_cnt   = 0;
        prev_grant    = '0;
        flt_busy      = 1'b0;
        rsp_busy      = '0;
        flt_res_vld   = 1'b0;
        flt_res_data  = '0;
        driveSources();
        stepCycle();
        stepCycle();
        flt_log.delete();
        grant_log.delete();
        rsp_src_log.delete();
        rsp_data_log.delete();
        rst = 1'b0;
    endtask

    task automatic waitRsp(input int n, input int budget);
        int c = 0;
        while (rsp_src_log.size() < n && c < budget) begin
            stepCycle();
            c++;
        end
        checkOutput("rspArrived", rsp_src_log.size(), n);
    endtask

    task automatic waitBeats(input int n, input int budget);
        int c = 0;
        while (flt_log.size() < n && c < budget) begin
            stepCycle();
            c++;
        end
        checkOutput("beatsArrived", flt_log.size(), n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int held_bad;

        // Single job from src1, plus reset values.
        applyReset();
        checkOutput("rstGrant", obs_grant, 0);
        checkOutput("rstSrcBusy", obs_src_busy, 4'hF);
        checkOutput("rstFltVld", obs_flt_vld, 0);
        checkOutput("rstRspVld", obs_rsp_vld, 0);
        checkOutput("rstFltResBusy", obs_flt_res_busy, 1);
        checkOutput("rstJobCnt", obs_job_cnt, 0);
        applyStimulus(1, 9);
        stepCycle();
        checkOutput("s1ArbLatency", obs_grant, 4'b0000);
        stepCycle();
        checkOutput("s1Grant", obs_grant, 4'b0010);
        checkOutput("s1SrcBusy", obs_src_busy, 4'b1101);
        checkOutput("s1FltVld", obs_flt_vld, 1);
        waitRsp(1, 60);
        checkOutput("s1Beats", flt_log.size(), 9);
        for (int i = 0; i < 9; i++) checkOutput("s1BeatData", flt_log[i], beatData(1, i + 1));
        checkOutput("s1RspSrc", rsp_src_log[0], 1);
        checkOutput("s1RspData", rsp_data_log[0], 24'h050505);
        stepCycle();
        checkOutput("s1JobCnt", obs_job_cnt, 1);
        checkOutput("s1Idle", obs_grant, 0);

        // All four sources valid from reset: rotation 0,1,2,3,0.
        applyReset();
        applyStimulus(0, 18);
        applyStimulus(1, 9);
        applyStimulus(2, 9);
        applyStimulus(3, 9);
        waitRsp(5, 300);
        repeat (3) stepCycle();
        checkOutput("s2Grants", grant_log.size(), 5);
        for (int j = 0; j < 5; j++) begin
            checkOutput("s2GrantOrder", grant_log[j], j % 4);
            checkOutput("s2RspSrc", rsp_src_log[j], j % 4);
            checkOutput("s2RspData", rsp_data_log[j], 24'h050505 + 24'(j));
        end
        checkOutput("s2Beats", flt_log.size(), 45);
        for (int j = 0; j < 5; j++)
            for (int b = 0; b < 9; b++)
                checkOutput("s2BeatData", flt_log[j*9 + b], beatData(j % 4, (j / 4) * 9 + b + 1));
        checkOutput("s2NonGrantedBeat", bad_src_cnt, 0);
        checkOutput("s2JobCnt", obs_job_cnt, 5);

        // Filter busy toggling every cycle during the feed.
        applyReset();
        toggle_busy = 1'b1;
        applyStimulus(2, 9);
        waitRsp(1, 80);
        toggle_busy = 1'b0;
        flt_busy    = 1'b0;
        checkOutput("s3Beats", flt_log.size(), 9);
        for (int i = 0; i < 9; i++) checkOutput("s3BeatData", flt_log[i], beatData(2, i + 1));
        checkOutput("s3SrcAccepted", next_beat[2], 9);
        checkOutput("s3RspSrc", rsp_src_log[0], 2);

        // Result presented early while still feeding.
        applyReset();
        auto_filter = 1'b0;
        applyStimulus(3, 9);
        waitBeats(4, 30);
        flt_res_vld  = 1'b1;
        flt_res_data = 24'h0ABCDE;
        held_bad = 0;
        for (int c = 0; c < 30 && flt_log.size() < 9; c++) begin
            stepCycle();
            if (obs_flt_res_busy !== 1'b1 || obs_rsp_vld !== '0 || obs_res_taken) held_bad++;
        end
        checkOutput("s4HeldInFeed", held_bad, 0);
        checkOutput("s4Beats", flt_log.size(), 9);
        stepCycle();
        checkOutput("s4RspVld", obs_rsp_vld, 4'b1000);
        checkOutput("s4RspData", obs_rsp_data, 24'h0ABCDE);
        checkOutput("s4Taken", obs_res_taken, 1);
        flt_res_vld = 1'b0;
        stepCycle();
        checkOutput("s4JobCnt", obs_job_cnt, 1);

        // Result sink busy for five cycles in WAIT.
        applyReset();
        rsp_busy = 4'b0100;
        applyStimulus(2, 9);
        waitBeats(9, 40);
        held_bad = 0;
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            if (obs_rsp_vld !== 4'b0100 || obs_flt_res_busy !== 1'b1) held_bad++;
        end
        checkOutput("s5HeldInWait", held_bad, 0);
        checkOutput("s5NoRspYet", rsp_src_log.size(), 0);
        rsp_busy = '0;
        stepCycle();
        checkOutput("s5FltResBusy", obs_flt_res_busy, 0);
        checkOutput("s5RspCount", rsp_src_log.size(), 1);
        checkOutput("s5RspData", rsp_data_log[0], 24'h050505);
        stepCycle();
        checkOutput("s5IdleAfter", obs_grant, 0);

        // Reset in the middle of a job (rr_ptr sits at 2 beforehand).
        applyReset();
        applyStimulus(1, 9);
        waitRsp(1, 60);
        applyStimulus(2, 9);
        waitBeats(13, 40);
        rst = 1'b1;
        applyStimulus(0, 100);
        stepCycle();
        stepCycle();
        checkOutput("s6Grant", obs_grant, 0);
        checkOutput("s6SrcBusy", obs_src_busy, 4'hF);
        checkOutput("s6FltVld", obs_flt_vld, 0);
        checkOutput("s6RspVld", obs_rsp_vld, 0);
        checkOutput("s6FltResBusy", obs_flt_res_busy, 1);
        checkOutput("s6JobCnt", obs_job_cnt, 0);
        rst          = 1'b0;
        flt_feed_cnt = 0;
        flt_res_vld  = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("s6RegrantSrc0", obs_grant, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
